// File: rtl/configurable_mux_pkg.sv
// Shared types and helpers for the round-robin N-to-1 merge.
package configurable_mux_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  function automatic int unsigned num_sources(input int unsigned sel_bits);
    return 32'd1 << sel_bits;
  endfunction

  function automatic int unsigned next_index(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_priority_picker
  import configurable_mux_pkg::*;
#(
  parameter int unsigned nb_bits_select = 1,
  localparam int unsigned N = num_sources(nb_bits_select)
) (
  input  logic [N-1:0]              valid_i,
  input  logic [nb_bits_select-1:0] ptr,
  output logic [nb_bits_select-1:0] grant,
  output logic [N-1:0]              grant_onehot,
  output logic                      any_req
);

  logic [2*N-1:0]            doubled;
  logic [2*N-1:0]            rotated;
  logic [nb_bits_select-1:0] offset;
  logic                      found;

  // Rotating the doubled vector right by ptr puts the search start at bit 0,
  // so the first set bit gives the distance from ptr to the winner.
  always_comb begin
    doubled = {valid_i, valid_i};
    rotated = doubled >> ptr;
    any_req = |valid_i;
    offset  = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && rotated[i]) begin
        offset = nb_bits_select'(i);
        found  = 1'b1;
      end
    end
    grant        = ptr + offset;
    grant_onehot = any_req ? ({{(N-1){1'b0}}, 1'b1} << grant) : '0;
  end

endmodule

// File: rtl/configurable_rr_mux.sv
// N-to-1 valid/ready merge with round-robin arbitration and a registered output.
module configurable_rr_mux
  import configurable_mux_pkg::*;
#(
  parameter int unsigned nb_bits_select        = 1,
  parameter int unsigned nb_bits_taille_donnes = 1,
  localparam int unsigned N = num_sources(nb_bits_select)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [N-1:0][nb_bits_taille_donnes-1:0] data_i,
  input  logic [N-1:0]                           valid_i,
  output logic [N-1:0]                           ready_o,
  output logic [nb_bits_taille_donnes-1:0]       data_o,
  output logic [nb_bits_select-1:0]              sel_o,
  output logic                                   valid_o,
  input  logic                                   ready_i
);

  out_state_e                 state_q, state_d;
  logic [nb_bits_select-1:0]  ptr_q;
  logic [nb_bits_select-1:0]  grant;
  logic [N-1:0]               grant_onehot;
  logic                       any_req;
  logic                       load_en;
  logic                       take;

  rr_priority_picker #(
    .nb_bits_select(nb_bits_select)
  ) u_picker (
    .valid_i      (valid_i),
    .ptr          (ptr_q),
    .grant        (grant),
    .grant_onehot (grant_onehot),
    .any_req      (any_req)
  );

  assign load_en = (state_q == EMPTY) || ready_i;
  assign take    = load_en && any_req && !rst_i;

  always_comb begin
    ready_o = '0;
    if (take) ready_o = grant_onehot;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (load_en) state_d = any_req ? FULL : EMPTY;
  end

  always_comb begin
    valid_o = (state_q == FULL);
  end

  // Payload and pointer only move on an accepted beat; a drain without refill leaves them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o <= '0;
      sel_o  <= '0;
      ptr_q  <= '0;
    end else if (take) begin
      data_o <= data_i[grant];
      sel_o  <= grant;
      ptr_q  <= nb_bits_select'(next_index(int'(grant), N));
    end
  end

endmodule

// File: tb/tb_configurable_rr_mux.sv
// Directed table-driven bench for configurable_rr_mux with 4 sources, 8-bit data.
module tb_configurable_rr_mux;

  localparam int unsigned SB = 2;
  localparam int unsigned DW = 8;
  localparam int unsigned NS = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NS-1:0][DW-1:0]  data;
  logic [NS-1:0]          valid;
  logic [NS-1:0]          ready_o;
  logic [DW-1:0]          data_o;
  logic [SB-1:0]          sel_o;
  logic                   valid_o;
  logic                   ready_i;

  int tests = 0;
  int fails = 0;

  configurable_rr_mux #(
    .nb_bits_select        (SB),
    .nb_bits_taille_donnes (DW)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .data_i  (data),
    .valid_i (valid),
    .ready_o (ready_o),
    .data_o  (data_o),
    .sel_o   (sel_o),
    .valid_o (valid_o),
    .ready_i (ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                  rst;
    logic [NS-1:0]         valid;
    logic                  rdy;
    logic [NS-1:0][DW-1:0] data;
    logic [NS-1:0]         exp_ready;
    logic                  exp_valid;
    logic [DW-1:0]         exp_data;
    logic [SB-1:0]         exp_sel;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic rd, input logic [NS-1:0][DW-1:0] d,
                     input logic [3:0] er, input logic ev, input logic [7:0] ed, input logic [1:0] es);
    vec_t t;
    t.rst = r; t.valid = v; t.rdy = rd; t.data = d;
    t.exp_ready = er; t.exp_valid = ev; t.exp_data = ed; t.exp_sel = es;
    vecs.push_back(t);
  endtask

  initial begin
    logic [NS-1:0][DW-1:0] d0, da5, d5a, dx;
    logic [NS-1:0] seen;
    d0  = {8'h13, 8'h12, 8'h11, 8'h10};
    da5 = {8'h13, 8'hA5, 8'h11, 8'h10};
    d5a = {8'h13, 8'h12, 8'h11, 8'h5A};
    dx  = {8'hxx, 8'hxx, 8'hxx, 8'h77};

    //   rst valid    rdy data  exp_ready v  data   sel
    add(1, 4'b1111, 1, d0,  4'b0000, 0, 8'h00, 0); // reset
    add(0, 4'b0100, 1, da5, 4'b0100, 1, 8'hA5, 2); // single source, ptr->3
    add(0, 4'b0000, 1, d0,  4'b0000, 0, 8'hA5, 2); // drain, payload holds
    add(1, 4'b1111, 1, d0,  4'b0000, 0, 8'h00, 0);
    add(0, 4'b1111, 1, d0,  4'b0001, 1, 8'h10, 0); // full load
    add(0, 4'b1111, 1, d0,  4'b0010, 1, 8'h11, 1);
    add(0, 4'b1111, 1, d0,  4'b0100, 1, 8'h12, 2);
    add(0, 4'b1111, 1, d0,  4'b1000, 1, 8'h13, 3);
    add(0, 4'b1111, 1, d0,  4'b0001, 1, 8'h10, 0);
    add(0, 4'b1111, 1, d0,  4'b0010, 1, 8'h11, 1);
    add(0, 4'b1111, 0, d0,  4'b0000, 1, 8'h11, 1); // backpressure x3
    add(0, 4'b1111, 0, d0,  4'b0000, 1, 8'h11, 1);
    add(0, 4'b1111, 0, d0,  4'b0000, 1, 8'h11, 1);
    add(0, 4'b1111, 1, d0,  4'b0100, 1, 8'h12, 2); // resumes at source 2
    add(0, 4'b1010, 1, d0,  4'b1000, 1, 8'h13, 3); // sparse alternation
    add(0, 4'b1010, 1, d0,  4'b0010, 1, 8'h11, 1);
    add(0, 4'b1010, 1, d0,  4'b1000, 1, 8'h13, 3);
    add(0, 4'b1010, 1, d0,  4'b0010, 1, 8'h11, 1);
    add(0, 4'b0100, 1, d0,  4'b0100, 1, 8'h12, 2); // full with sel 2
    add(1, 4'b1111, 1, d0,  4'b0000, 0, 8'h00, 0); // reset mid-operation
    add(0, 4'b1111, 1, d0,  4'b0001, 1, 8'h10, 0);
    add(0, 4'b0000, 1, d0,  4'b0000, 0, 8'h10, 0); // ptr now 1
    add(0, 4'b0001, 0, d5a, 4'b0001, 1, 8'h5A, 0); // empty accepts despite ready_i=0, wrap search
    add(0, 4'b1111, 0, d0,  4'b0000, 1, 8'h5A, 0);
    add(0, 4'b1111, 1, d0,  4'b0010, 1, 8'h11, 1);
    add(0, 4'b0001, 1, dx,  4'b0001, 1, 8'h77, 0); // non-requesting data is X

    rst = 1'b1; valid = '0; ready_i = 1'b0; data = d0;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; valid = vecs[i].valid; ready_i = vecs[i].rdy; data = vecs[i].data;
      #1;
      check("ready_o", i, 32'(ready_o), 32'(vecs[i].exp_ready));
      @(posedge clk);
      #1;
      check("valid_o", i, 32'(valid_o), 32'(vecs[i].exp_valid));
      check("data_o",  i, 32'(data_o),  32'(vecs[i].exp_data));
      check("sel_o",   i, 32'(sel_o),   32'(vecs[i].exp_sel));
    end

    // Fairness / no bubbles: ptr is 1, all requesting, ready held -> 1,2,3,0 in 4 cycles.
    seen = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rst = 1'b0; valid = 4'b1111; ready_i = 1'b1; data = d0;
      #1;
      check("ready_onehot", k, 32'($onehot(ready_o)), 32'd1);
      check("fair_grant", k, 32'(ready_o), 32'(4'b0001 << ((k + 1) % 4)));
      seen = seen | ready_o;
      @(posedge clk);
      #1;
      check("no_bubble", k, 32'(valid_o), 32'd1);
      check("fair_sel", k, 32'(sel_o), 32'((k + 1) % 4));
    end
    check("all_served", 0, 32'(seen), 32'(4'b1111));

    // Hold FULL under backpressure with data changing on inputs: payload must not move.
    @(negedge clk);
    ready_i = 1'b0; data = {8'hEE, 8'hEE, 8'hEE, 8'hEE};
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("bp_hold_data", k, 32'(data_o), 32'h10);
      check("bp_hold_sel", k, 32'(sel_o), 32'd0);
      check("bp_ready", k, 32'(ready_o), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
